// File: rtl/mem_resp_pkg.sv
// Shared definitions for the memory responder slice.
// Holds the default geometry and latencies, the controller state encoding
// and a small helper used to size the latency counter.
// No ports (package).
package mem_resp_pkg;

  localparam int DEF_ADDR_W     = 26;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_SRAM_AW    = 16;
  localparam int DEF_RD_LATENCY = 3;
  localparam int DEF_WR_LATENCY = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_e;

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_sp.sv
// Single-port on-chip SRAM with a one-cycle registered read port.
// Ports:
//   clk_i   - clock, rising edge
//   en_i    - access enable (read when we_i is low, write when high)
//   we_i    - write enable
//   addr_i  - word address
//   wdata_i - write data
//   rdata_o - registered read data, holds its value when not reading
module sram_sp #(
  parameter int AW = 16,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];

  // Storage has no reset so contents survive a controller reset.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_o <= mem_q[addr_i];
      end
    end
  end

endmodule

// File: rtl/mem_resp_ctrl.sv
// Memory responder: serves one read or write request at a time against a
// single-port SRAM, with fixed read/write latencies, round-robin arbitration
// and a same-address write-first override.
// Optional feature: define MEM_RESP_BOUNDS_EN to flag out-of-range requests
// (upper address bits nonzero) on a sticky err output; without it the upper
// address bits are ignored and addresses alias.
// Ports:
//   clk            - clock, rising edge
//   rst_n          - synchronous active-low reset
//   wvalid/wready  - write request / one-cycle write-done pulse
//   waddr/wdata    - write address and data, held by the initiator
//   rvalid/rready  - read request / one-cycle read-data-valid pulse
//   raddr/rdata    - read address / read data (held between reads)
//   err            - sticky out-of-range flag (MEM_RESP_BOUNDS_EN only)
module mem_resp_ctrl
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int SRAM_AW    = DEF_SRAM_AW,
  parameter int RD_LATENCY = DEF_RD_LATENCY,
  parameter int WR_LATENCY = DEF_WR_LATENCY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wvalid,
  output logic              wready,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rvalid,
  output logic              rready,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
`ifdef MEM_RESP_BOUNDS_EN
  ,
  output logic              err
`endif
);

  localparam int CNT_W = $clog2(maxOf(RD_LATENCY, WR_LATENCY) + 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0] RD_PRE  = CNT_W'(RD_LATENCY - 2);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_LATENCY - 1);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic                favorRead_q;
  logic                wready_q;
  logic                rready_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                rdInRange;
  logic                wrInRange;
  logic                sameIdx;
  logic                grantWr;
  logic                grantRd;
  logic                sramEn;
  logic                sramWe;
  logic [SRAM_AW-1:0]  sramAddr;
  logic [DATA_W-1:0]   sramRdata;

`ifdef MEM_RESP_BOUNDS_EN
  logic                err_q;

  assign rdInRange = (raddr[ADDR_W-1:SRAM_AW] == '0);
  assign wrInRange = (waddr[ADDR_W-1:SRAM_AW] == '0);
  assign err       = err_q;
`else
  logic                unusedUpperBits;

  // Upper bits are deliberately dropped, so every address aliases into the SRAM.
  assign rdInRange       = 1'b1;
  assign wrInRange       = 1'b1;
  assign unusedUpperBits = ^{raddr[ADDR_W-1:SRAM_AW], waddr[ADDR_W-1:SRAM_AW]};
`endif

  assign cnt_d  = cnt_q + CNT_W'(1);
  assign wready = wready_q;
  assign rready = rready_q;
  assign rdata  = rdata_q;

  // Arbitration in IDLE: a write to the same SRAM word as a pending read goes
  // first so the read sees the new data; otherwise alternate on contention.
  always_comb begin
    sameIdx = (raddr[SRAM_AW-1:0] == waddr[SRAM_AW-1:0]);
    grantWr = wvalid && (!rvalid || sameIdx || !favorRead_q);
    grantRd = rvalid && !grantWr;
  end

  // The SRAM read is launched one cycle before the read completes to cover
  // its registered output; the write lands at the edge that raises wready.
  // Gating with rst_n keeps a reset edge from committing an in-flight write.
  always_comb begin
    sramAddr = (state_q == WR_WAIT) ? waddr[SRAM_AW-1:0] : raddr[SRAM_AW-1:0];
    sramWe   = rst_n && (state_q == WR_WAIT) && (cnt_q == WR_LAST)
               && wvalid && wrInRange;
    sramEn   = sramWe || ((state_q == RD_WAIT) && (cnt_q == RD_PRE) && rvalid);
  end

  sram_sp #(
    .AW (SRAM_AW),
    .DW (DATA_W)
  ) u_sram (
    .clk_i   (clk),
    .en_i    (sramEn),
    .we_i    (sramWe),
    .addr_i  (sramAddr),
    .wdata_i (wdata),
    .rdata_o (sramRdata)
  );

  // Controller FSM. Ready pulses are registered and last one cycle; the FSM is
  // already back in IDLE during the pulse, so the next request is sampled at
  // the following edge. Dropping valid while waiting aborts silently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      favorRead_q <= 1'b1;
      wready_q    <= 1'b0;
      rready_q    <= 1'b0;
      rdata_q     <= '0;
`ifdef MEM_RESP_BOUNDS_EN
      err_q       <= 1'b0;
`endif
    end else begin
      wready_q <= 1'b0;
      rready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (grantWr) begin
            state_q <= WR_WAIT;
            if (rvalid) begin
              favorRead_q <= 1'b1;
            end
          end else if (grantRd) begin
            state_q <= RD_WAIT;
            if (wvalid) begin
              favorRead_q <= 1'b0;
            end
          end
        end
        RD_WAIT: begin
          if (!rvalid) begin
            state_q <= IDLE;
          end else if (cnt_q == RD_LAST) begin
            rready_q <= 1'b1;
            rdata_q  <= rdInRange ? sramRdata : '0;
            state_q  <= IDLE;
`ifdef MEM_RESP_BOUNDS_EN
            if (!rdInRange) begin
              err_q <= 1'b1;
            end
`endif
          end else begin
            cnt_q <= cnt_d;
          end
        end
        WR_WAIT: begin
          if (!wvalid) begin
            state_q <= IDLE;
          end else if (cnt_q == WR_LAST) begin
            wready_q <= 1'b1;
            state_q  <= IDLE;
`ifdef MEM_RESP_BOUNDS_EN
            if (!wrInRange) begin
              err_q <= 1'b1;
            end
`endif
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
